sbox_layer_sequencer: RTL and testbench
=======================================

# sbox_layer_sequencer

Serial substitution-layer controller for the cipher datapath. It applies the existing 4-bit `SBox` to every nibble of a 64-bit cipher state, one nibble per cycle, through a single shared `SBox` instance. Upstream round logic hands it a state over a valid/ready handshake and receives the fully substituted state back over a second valid/ready handshake. This trades 16 cycles of latency for one S-box instead of sixteen.

## Interface
- `NIBBLES`, default 16: number of 4-bit nibbles in the state. The state width is `4*NIBBLES`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  upstream presents `in_state`.
- `in_ready`  out  1  block can accept a new state.
- `in_state`  in  4*NIBBLES  state to substitute.
- `out_valid`  out  1  `out_state` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  4*NIBBLES  substituted state.
- `busy`  out  1  high while in SUB or DONE.

## Operation
- Internal resources:
  - One `SBox` instance, wired as `SBox(.substituted(sb_out), .orig(sb_in))`, combinational.
  - A `4*NIBBLES` state register `st`.
  - A counter `cnt` of width `$clog2(NIBBLES)`.
  - A 2-bit FSM with states IDLE, SUB and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` && `in_ready`: `st` <= `in_state`, `cnt` <= 0, go to SUB.
  - Otherwise hold all registers.
- SUB:
  - `sb_in` = `st[3:0]`.
  - Each cycle: `st` <= {`sb_out`, `st[4*NIBBLES-1:4]`}. This rotates right by one nibble and inserts the substituted nibble at the top.
  - `cnt` <= `cnt`+1.
  - When `cnt`==`NIBBLES`-1 on the edge, go to DONE. After exactly `NIBBLES` shifts every nibble is substituted and back in its original position.
- DONE:
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored.
- `out_state` is `st`, driven continuously. It is meaningful only while `out_valid`=1 and is stable for the whole DONE state.
- `in_ready` = (state==IDLE) && reset deasserted.
- `busy` = (state!=IDLE).
- `sb_in` is 0 outside SUB, so the S-box input does not toggle when unused.
- `SBox` implements the PRESENT table: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.

## Timing
- Reset (asynchronous, `reset`=0):
  - State -> IDLE; `st`=0; `cnt`=0.
  - `out_valid`=0, `busy`=0, `in_ready`=0 while asserted.
  - `in_ready`=1 in the first cycle after release.
- Latency:
  - Call the acceptance edge E0.
  - The SUB edges E1..E16 process nibbles 0..15.
  - `out_valid` rises after E16, i.e. 16 cycles after acceptance (`NIBBLES` in general).
- Throughput:
  - Output handshake at the earliest at E17, which returns the FSM to IDLE.
  - The next accept is at E18, giving one state per `NIBBLES`+2 cycles.
- No overlap: a new input is never accepted in the same cycle as an output handshake.
- Backpressure:
  - `out_valid` stays high and `out_state` stays unchanged for any number of cycles with `out_ready`=0.
  - No new input is accepted meanwhile.
- `out_ready` outside DONE has no effect. `in_valid` outside IDLE has no effect.
- Reset mid-SUB or mid-DONE:
  - The operation is discarded and `out_valid` drops immediately.
  - The result is not delivered; the next transaction behaves as if freshly reset.
- `cnt` wrap: `cnt` reaches `NIBBLES`-1 and is reloaded to 0 only on acceptance, never free-running.

## Test plan
- **Zero state:** reset, accept `in_state`=0.
  - `out_valid` rises exactly 16 cycles after the accept edge.
  - `out_state`=0xCCCC_CCCC_CCCC_CCCC.
- **Full table coverage:** accept 0x0123_4567_89AB_CDEF -> `out_state`=0xC56B_90AD_3EF8_4712.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with 0xFFFF_FFFF_FFFF_FFFF.
  - `out_state` stays stable, `in_ready`=0 and nothing is captured.
  - Then raise `out_ready`: the FSM returns to IDLE and the next accept yields 0x2222_2222_2222_2222.
- **Reset abort:**
  - Assert `reset`=0 on the 8th SUB cycle of 0x0123_4567_89AB_CDEF.
  - `out_valid` never pulses, `busy`=0 immediately, and `in_ready`=1 after release.
  - Rerunning the same input gives 0xC56B_90AD_3EF8_4712.
- **Back-to-back:**
  - Keep `in_valid` and `out_ready` permanently high and stream 4 random states.
  - Accepts are spaced exactly 18 cycles apart.
  - Each result matches the per-nibble reference-model substitution.
- **Idle hygiene:** with `in_valid`=0 for 50 cycles after reset: `busy`=0, `out_valid`=0, `out_state`=0.

Source files
------------

// File: rtl/sbox_layer_sequencer.sv
// Serial substitution layer: pushes every nibble of the cipher state through one
// shared PRESENT S-box, one nibble per cycle, with valid/ready on both sides.
module sbox_layer_sequencer #(
  parameter int unsigned NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_state,
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  st;
  logic [CW-1:0] cnt;
  logic          idle_q;
  logic [3:0]    sb_in;
  logic [3:0]    sb_out;

  // S-box input parked at zero outside SUB so it does not toggle when unused
  always_comb begin
    sb_in = '0;
    if (state == SUB) sb_in = st[3:0];
  end

  SBox u_sbox (
    .substituted(sb_out),
    .orig       (sb_in)
  );

  // idle_q is held high through reset; gating with reset keeps in_ready low while asserted
  assign in_ready  = idle_q & reset;
  assign out_state = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      st        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st     <= in_state;
            cnt    <= '0;
            state  <= SUB;
            busy   <= 1'b1;
            idle_q <= 1'b0;
          end
        end
        SUB: begin
          // rotate right one nibble; after NIBBLES shifts each nibble is home again
          st  <= {sb_out, st[W-1:4]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idle_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// PRESENT 4-bit S-box, purely combinational.
module SBox (
  output logic [3:0] substituted,
  input  logic [3:0] orig
);

  always_comb begin
    substituted = 4'hC;
    unique case (orig)
      4'h0: substituted = 4'hC;
      4'h1: substituted = 4'h5;
      4'h2: substituted = 4'h6;
      4'h3: substituted = 4'hB;
      4'h4: substituted = 4'h9;
      4'h5: substituted = 4'h0;
      4'h6: substituted = 4'hA;
      4'h7: substituted = 4'hD;
      4'h8: substituted = 4'h3;
      4'h9: substituted = 4'hE;
      4'hA: substituted = 4'hF;
      4'hB: substituted = 4'h8;
      4'hC: substituted = 4'h4;
      4'hD: substituted = 4'h7;
      4'hE: substituted = 4'h1;
      4'hF: substituted = 4'h2;
      default: substituted = 4'hC;
    endcase
  end

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Directed bench for sbox_layer_sequencer: latency, table coverage, backpressure,
// reset abort, back-to-back streaming and idle behaviour.
module tb_sbox_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_state;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_state;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // nibble i of this word is S(i)
  logic [63:0] present_tbl = 64'h2174_8FE3_DA09_B65C;

  sbox_layer_sequencer #(.NIBBLES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_sub(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = present_tbl[4*x[4*i +: 4] +: 4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] d);
    in_state = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [63:0] held;
    logic [63:0] exp_q[$];
    int          acc_cyc[$];
    int          cyc;
    int          n_acc;
    int          n_res;
    logic        acc;
    logic        hs;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_state", out_state,      64'd0);
    #5 reset = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // idle hygiene
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy || out_valid || out_state != 64'd0 || !in_ready) bad++;
    end
    check("idle_hygiene", 64'(bad), 64'd0);

    // zero state
    accept(64'd0);
    check("zero_busy",     64'(busy),     64'd1);
    check("zero_in_ready", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("zero_latency", 64'(lat), 64'd16);
    check("zero_result",  out_state, 64'hCCCC_CCCC_CCCC_CCCC);
    take_output();
    check("zero_ov_drop",  64'(out_valid), 64'd0);
    check("zero_idle_rdy", 64'(in_ready),  64'd1);

    // full table coverage
    accept(64'h0123_4567_89AB_CDEF);
    wait_done(lat);
    check("tbl_latency", 64'(lat), 64'd16);
    check("tbl_result",  out_state, 64'hC56B_90AD_3EF8_4712);

    // backpressure while an input is offered
    held     = out_state;
    in_state = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_state", out_state,      held);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ov",   64'(out_valid), 64'd0);
    check("bp_release_busy", 64'(busy),      64'd0);
    check("bp_release_rdy",  64'(in_ready),  64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", 64'(busy), 64'd1);
    wait_done(lat);
    check("bp_next_latency", 64'(lat), 64'd16);
    check("bp_next_result",  out_state, 64'h2222_2222_2222_2222);
    take_output();

    // reset during the 8th SUB cycle
    accept(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 7; i++) tick();
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd0);
    check("abort_st_clear",  out_state,      64'd0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (out_valid || busy) bad++;
    end
    #2 reset = 1'b1;
    #1;
    check("abort_release_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || busy) bad++;
    end
    check("abort_no_pulse", 64'(bad), 64'd0);
    accept(64'h0123_4567_89AB_CDEF);
    wait_done(lat);
    check("rerun_latency", 64'(lat), 64'd16);
    check("rerun_result",  out_state, 64'hC56B_90AD_3EF8_4712);
    take_output();

    // back-to-back streaming
    in_state  = {$urandom, $urandom};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc   = 0;
    n_acc = 0;
    n_res = 0;
    while (n_res < 4 && cyc < 300) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() > 0) check("b2b_result", out_state, exp_q.pop_front());
        else check("b2b_unexpected_out", 64'd1, 64'd0);
        n_res++;
      end
      if (acc) exp_q.push_back(ref_sub(in_state));
      tick();
      cyc++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        n_acc++;
        if (n_acc == 4) in_valid = 1'b0;
        else in_state = {$urandom, $urandom};
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_result_count", 64'(n_res), 64'd4);
    check("b2b_accept_count", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
